pe_grid_ctrl: RTL and testbench

Pass sequencer for the 12x14 PE grid. On each start it runs one pass in three phases:
- Loads 12 row-weight vectors into the grid, one row per accepted beat, by driving tag_row/valid_y.
- Streams a configured number of image column vectors into the grid.
- Waits out the fixed psum latency, then flags psum_outs as valid one beat per streamed image vector.

It sits between the weight/image buffers (valid/ready streams) and the grid's raw, non-stallable inputs.

---
 rtl/pe_grid_pkg.sv | 21 ++
 rtl/psum_valid_delay.sv | 26 ++
 rtl/pe_grid_ctrl.sv | 152 +++++++++++++++
 tb/tb_pe_grid_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pe_grid_pkg.sv
// Shared types and grid geometry for the PE grid pass sequencer.
package pe_grid_pkg;

   localparam int NUM_ROWS = 12;
   localparam int NUM_COLS = 14;
   localparam int DATA_W   = 16;
   localparam int PSUM_W   = 32;
   localparam int ROW_ID_W = 4;

   typedef logic [DATA_W-1:0] elem_t;
   typedef elem_t vec_t [NUM_COLS];

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/psum_valid_delay.sv
// Fixed-depth 1-bit delay line that mirrors image beats onto psum_valid.
module psum_valid_delay #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic clr_i,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sr_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         sr_q <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_grid_ctrl.sv
// Pass sequencer: loads row weights, streams image vectors, then waits for
// the grid's psum latency before signalling done.
module pe_grid_ctrl
   import pe_grid_pkg::*;
#(
   parameter int PIX_W    = 16,
   parameter int PSUM_LAT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [PIX_W-1:0]    cfg_num_pix,
   output logic                busy,
   output logic                done,
   input  vec_t                w_vec,
   input  logic                w_valid,
   output logic                w_ready,
   input  vec_t                img_vec,
   input  logic [NUM_COLS-1:0] img_elem_valid,
   input  logic                img_valid,
   output logic                img_ready,
   output vec_t                row_weight_vals,
   output logic [ROW_ID_W-1:0] tag_row,
   output logic                valid_y,
   output vec_t                image_val_vec,
   output logic [NUM_COLS-1:0] valid_x_vec,
   output logic                psum_valid
);

   ctrl_state_t         state_q, state_d;
   logic [ROW_ID_W-1:0] row_cnt_q, row_cnt_d;
   logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [PIX_W-1:0]    num_pix_q, num_pix_d;
   logic [3:0]          drain_cnt_q, drain_cnt_d;
   logic                w_acc, img_acc;

   vec_t                row_weight_q, image_q;
   logic [ROW_ID_W-1:0] tag_row_q;
   logic                valid_y_q;
   logic [NUM_COLS-1:0] valid_x_q;
   logic                beat_q;

   assign w_ready   = (state_q == LOAD_W);
   assign img_ready = (state_q == STREAM);
   assign w_acc     = w_ready && w_valid;
   assign img_acc   = img_ready && img_valid;
   assign busy      = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
   assign done      = (state_q == DONE);

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      num_pix_d   = num_pix_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               num_pix_d = cfg_num_pix;
               row_cnt_d = '0;
               state_d   = LOAD_W;
            end
         end
         LOAD_W: begin
            if (w_acc) begin
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == ROW_ID_W'(NUM_ROWS - 1)) begin
                  pix_cnt_d = '0;
                  state_d   = (num_pix_q == '0) ? DONE : STREAM;
               end
            end
         end
         STREAM: begin
            if (img_acc) begin
               pix_cnt_d = pix_cnt_q + 1'b1;
               if (pix_cnt_q == num_pix_q - 1'b1) begin
                  drain_cnt_d = '0;
                  state_d     = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Hold until the last beat has emerged from the delay line.
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (drain_cnt_q == 4'(PSUM_LAT)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         pix_cnt_q   <= '0;
         num_pix_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         num_pix_q   <= num_pix_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Grid inputs cannot stall, so strobes are driven for exactly one cycle per accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_weight_q <= '{default: '0};
         image_q      <= '{default: '0};
         tag_row_q    <= '0;
         valid_y_q    <= 1'b0;
         valid_x_q    <= '0;
         beat_q       <= 1'b0;
      end else begin
         valid_y_q <= w_acc;
         valid_x_q <= img_acc ? img_elem_valid : '0;
         beat_q    <= img_acc;
         if (w_acc) begin
            row_weight_q <= w_vec;
            tag_row_q    <= row_cnt_q;
         end
         if (img_acc) begin
            image_q <= img_vec;
         end
      end
   end

   assign row_weight_vals = row_weight_q;
   assign image_val_vec   = image_q;
   assign tag_row         = tag_row_q;
   assign valid_y         = valid_y_q;
   assign valid_x_vec     = valid_x_q;

   psum_valid_delay #(
      .DEPTH(PSUM_LAT)
   ) u_psum_delay (
      .clk  (clk),
      .clr_i(rst),
      .d_i  (beat_q),
      .q_o  (psum_valid)
   );

endmodule

// File: tb/tb_pe_grid_ctrl.sv
// Directed bench for pe_grid_ctrl: per-cycle activity is logged into bit masks
// and compared against hand-derived cycle patterns for each scenario.
module tb_pe_grid_ctrl;
   import pe_grid_pkg::*;

   localparam int PIX_W    = 16;
   localparam int PSUM_LAT = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [PIX_W-1:0]    cfg_num_pix;
   logic                busy, done;
   vec_t                w_vec;
   logic                w_valid, w_ready;
   vec_t                img_vec;
   logic [NUM_COLS-1:0] img_elem_valid;
   logic                img_valid, img_ready;
   vec_t                row_weight_vals;
   logic [ROW_ID_W-1:0] tag_row;
   logic                valid_y;
   vec_t                image_val_vec;
   logic [NUM_COLS-1:0] valid_x_vec;
   logic                psum_valid;

   int checks = 0;
   int errors = 0;

   // Bit k of each log holds the signal observed in cycle k after the start edge.
   logic [63:0]         vyLog, psLog, dnLog, bzLog, irLog;
   int                  bothReady, vyCount, wSent;
   logic [NUM_COLS-1:0] capValidX;
   vec_t                capImg;

   always #5 clk = ~clk;

   pe_grid_ctrl #(
      .PIX_W   (PIX_W),
      .PSUM_LAT(PSUM_LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .cfg_num_pix    (cfg_num_pix),
      .busy           (busy),
      .done           (done),
      .w_vec          (w_vec),
      .w_valid        (w_valid),
      .w_ready        (w_ready),
      .img_vec        (img_vec),
      .img_elem_valid (img_elem_valid),
      .img_valid      (img_valid),
      .img_ready      (img_ready),
      .row_weight_vals(row_weight_vals),
      .tag_row        (tag_row),
      .valid_y        (valid_y),
      .image_val_vec  (image_val_vec),
      .valid_x_vec    (valid_x_vec),
      .psum_valid     (psum_valid)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one pass started in cycle 0; startAt/rstAt/capAt < 1 disable those events.
   task automatic applyStimulus(input int numPix, input bit wAlt, input bit img3, input int nCyc,
                                input int startAt, input int rstAt, input int capAt);
      vyLog = '0; psLog = '0; dnLog = '0; bzLog = '0; irLog = '0;
      bothReady = 0; vyCount = 0; wSent = 0;
      cfg_num_pix = PIX_W'(numPix);
      start = 1'b1; w_valid = 1'b0; img_valid = 1'b0; rst = 1'b0;
      for (int k = 1; k <= nCyc; k++) begin
         tick();
         if (valid_y) begin
            checkOutput("tagRow", 64'(tag_row), 64'(vyCount));
            checkOutput("rowWeight", 64'(row_weight_vals[3]), 64'(vyCount + 1));
            vyCount++;
         end
         vyLog[k] = valid_y;
         psLog[k] = psum_valid;
         dnLog[k] = done;
         bzLog[k] = busy;
         irLog[k] = img_ready;
         if (w_ready && img_ready) bothReady++;
         if (k == capAt) begin
            capValidX = valid_x_vec;
            capImg    = image_val_vec;
         end
         if (k == rstAt + 1) begin
            checkOutput("rstBusy", 64'(busy), 64'd0);
            checkOutput("rstWReady", 64'(w_ready), 64'd0);
            checkOutput("rstImgReady", 64'(img_ready), 64'd0);
            checkOutput("rstValidY", 64'(valid_y), 64'd0);
            checkOutput("rstTagRow", 64'(tag_row), 64'd0);
            checkOutput("rstValidX", 64'(valid_x_vec), 64'd0);
            checkOutput("rstRowWeight", 64'(row_weight_vals[0]), 64'd0);
            checkOutput("rstImage", 64'(image_val_vec[0]), 64'd0);
         end
         start = (k == startAt);
         if (k == startAt) cfg_num_pix = 16'd9;
         rst       = (k == rstAt);
         w_valid   = wAlt ? k[0] : 1'b1;
         img_valid = img3 ? (k % 3 == 0) : 1'b1;
         for (int c = 0; c < NUM_COLS; c++) w_vec[c] = 16'(wSent + 1);
         if (w_valid && w_ready && !rst) wSent++;
      end
      start = 1'b0; w_valid = 1'b0; img_valid = 1'b0; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_num_pix = '0;
      w_valid = 1'b0; img_valid = 1'b0; img_elem_valid = 14'h3FFF;
      for (int c = 0; c < NUM_COLS; c++) begin
         w_vec[c]   = '0;
         img_vec[c] = 16'(c);
      end
      tick();
      tick();
      checkOutput("resetBusy", 64'(busy), 64'd0);
      checkOutput("resetDone", 64'(done), 64'd0);
      checkOutput("resetWReady", 64'(w_ready), 64'd0);
      checkOutput("resetImgReady", 64'(img_ready), 64'd0);
      checkOutput("resetValidY", 64'(valid_y), 64'd0);
      checkOutput("resetValidX", 64'(valid_x_vec), 64'd0);
      checkOutput("resetPsum", 64'(psum_valid), 64'd0);
      checkOutput("resetTagRow", 64'(tag_row), 64'd0);
      rst = 1'b0;
      tick();

      $display("[TB] basic pass");
      applyStimulus(4, 1'b0, 1'b0, 26, 0, -1, 14);
      checkOutput("basicValidY", vyLog, 64'h3FFC);
      checkOutput("basicPsum", psLog, 64'h1E0000);
      checkOutput("basicDone", dnLog, 64'h200000);
      checkOutput("basicBusy", bzLog, 64'h1FFFFE);
      checkOutput("basicValidX", 64'(capValidX), 64'h3FFF);
      checkOutput("basicImage5", 64'(capImg[5]), 64'd5);

      $display("[TB] backpressure gaps");
      applyStimulus(3, 1'b1, 1'b1, 40, 0, -1, 0);
      checkOutput("gapValidY", vyLog, 64'h1555554);
      checkOutput("gapPsum", psLog, 64'h490000000);
      checkOutput("gapDone", dnLog, 64'h800000000);
      checkOutput("gapBusy", bzLog, 64'h7FFFFFFFE);
      checkOutput("gapBothReady", 64'(bothReady), 64'd0);

      $display("[TB] zero pixels");
      applyStimulus(0, 1'b0, 1'b0, 18, 0, -1, 0);
      checkOutput("zeroValidY", vyLog, 64'h3FFC);
      checkOutput("zeroImgReady", irLog, 64'h0);
      checkOutput("zeroPsum", psLog, 64'h0);
      checkOutput("zeroDone", dnLog, 64'h2000);
      checkOutput("zeroBusy", bzLog, 64'h1FFE);

      $display("[TB] start while busy and in done cycle");
      applyStimulus(2, 1'b0, 1'b0, 26, 13, -1, 0);
      checkOutput("sbPsum", psLog, 64'h60000);
      checkOutput("sbDone", dnLog, 64'h80000);
      checkOutput("sbBusy", bzLog, 64'h7FFFE);
      applyStimulus(2, 1'b0, 1'b0, 26, 19, -1, 0);
      checkOutput("sdDone", dnLog, 64'h80000);
      checkOutput("sdBusy", bzLog, 64'h7FFFE);

      $display("[TB] reset mid-stream");
      applyStimulus(5, 1'b0, 1'b0, 22, 0, 15, 0);
      checkOutput("rstPsumLog", psLog, 64'h0);
      checkOutput("rstDoneLog", dnLog, 64'h0);
      checkOutput("rstBusyLog", bzLog, 64'hFFFE);
      applyStimulus(4, 1'b0, 1'b0, 26, 0, -1, 0);
      checkOutput("cleanValidY", vyLog, 64'h3FFC);
      checkOutput("cleanPsum", psLog, 64'h1E0000);
      checkOutput("cleanDone", dnLog, 64'h200000);

      $display("[TB] partial column valids");
      img_elem_valid = 14'h2AAA;
      applyStimulus(1, 1'b0, 1'b0, 22, 0, -1, 14);
      checkOutput("partValidX", 64'(capValidX), 64'h2AAA);
      checkOutput("partImage0", 64'(capImg[0]), 64'd0);
      checkOutput("partImage7", 64'(capImg[7]), 64'd7);
      checkOutput("partImage13", 64'(capImg[13]), 64'd13);
      checkOutput("partPsum", psLog, 64'h20000);
      checkOutput("partDone", dnLog, 64'h40000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
